// File: rtl/pe_pkg.sv
// Shared types, default parameters and fixed-point helpers for the
// weight/output-stationary processing element.
package pe_pkg;

   typedef enum logic {
      PE_MODE_WS = 1'b0,
      PE_MODE_OS = 1'b1
   } pe_mode_e;

   localparam int PE_DATA_WIDTH_DEF = 16;
   localparam int PE_FRAC_BITS_DEF  = 8;
   localparam int PE_ACC_WIDTH_DEF  = 40;
   localparam int PE_SATURATE_DEF   = 1;

   // Wide scratch type used by the helpers so that one set of functions
   // serves every operand width used in the PE.
   localparam int PE_CALC_W = 128;
   typedef logic signed [PE_CALC_W-1:0] pe_calc_t;
   localparam pe_calc_t PE_CALC_ONE = 128'sd1;

   // Round half up, then drop 'frac' fractional bits (frac >= 1).
   function automatic pe_calc_t fxp_round_shift(input pe_calc_t value, input int frac);
      pe_calc_t half;
      half = PE_CALC_ONE <<< (frac - 1);
      return (value + half) >>> frac;
   endfunction

   // Two's-complement wrap of 'value' to 'width' bits, sign-extended back.
   function automatic pe_calc_t wrap_signed(input pe_calc_t value, input int width);
      return (value <<< (PE_CALC_W - width)) >>> (PE_CALC_W - width);
   endfunction

   // True when 'value' is representable as a signed 'width'-bit number.
   function automatic logic fits_signed(input pe_calc_t value, input int width);
      return (wrap_signed(value, width) == value);
   endfunction

   // Clamp to the signed 'width'-bit range when 'sat' is set, else wrap.
   function automatic pe_calc_t sat_signed(input pe_calc_t value, input int width,
                                           input logic sat);
      pe_calc_t max_v;
      pe_calc_t min_v;
      pe_calc_t res;
      max_v = (PE_CALC_ONE <<< (width - 1)) - PE_CALC_ONE;
      min_v = -(PE_CALC_ONE <<< (width - 1));
      if (fits_signed(value, width)) begin
         res = value;
      end else if (sat) begin
         if (value < min_v) begin
            res = min_v;
         end else begin
            res = max_v;
         end
      end else begin
         res = wrap_signed(value, width);
      end
      return res;
   endfunction

endpackage

// File: rtl/pe_fxp_mac.sv
// Combinational fixed-point arithmetic of the PE: product, rounding,
// WS psum add, OS accumulate and OS drain, each with overflow detection.
module pe_fxp_mac
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = PE_DATA_WIDTH_DEF,
   parameter int FRAC_BITS  = PE_FRAC_BITS_DEF,
   parameter int ACC_WIDTH  = PE_ACC_WIDTH_DEF,
   parameter int SATURATE   = PE_SATURATE_DEF
) (
   input  logic signed [DATA_WIDTH-1:0] act_in,
   input  logic signed [DATA_WIDTH-1:0] weight,
   input  logic signed [DATA_WIDTH-1:0] psum_in,
   input  logic signed [ACC_WIDTH-1:0]  acc,
   output logic signed [DATA_WIDTH-1:0] ws_psum,
   output logic                         ws_ovf,
   output logic signed [ACC_WIDTH-1:0]  acc_sum,
   output logic                         acc_ovf,
   output logic signed [ACC_WIDTH-1:0]  prod_ext,
   output logic signed [DATA_WIDTH-1:0] drain_psum,
   output logic                         drain_ovf
);

   // The WS sum is formed at this width before it is clamped to DATA_WIDTH.
   localparam int   SUM_W  = DATA_WIDTH + FRAC_BITS + 2;
   localparam logic SAT_EN = (SATURATE != 0);

   pe_calc_t prod_c;
   pe_calc_t rnd_c;
   pe_calc_t sum_c;
   pe_calc_t ws_c;
   pe_calc_t accsum_c;
   pe_calc_t acc_c;
   pe_calc_t drain_raw_c;
   pe_calc_t drain_c;

   // Full-precision product and the three result paths derived from it.
   always_comb begin
      prod_c      = pe_calc_t'(act_in) * pe_calc_t'(weight);
      prod_ext    = prod_c[ACC_WIDTH-1:0];

      rnd_c       = fxp_round_shift(prod_c, FRAC_BITS);
      sum_c       = wrap_signed(rnd_c + pe_calc_t'(psum_in), SUM_W);
      ws_c        = sat_signed(sum_c, DATA_WIDTH, SAT_EN);
      ws_ovf      = ~fits_signed(sum_c, DATA_WIDTH);
      ws_psum     = ws_c[DATA_WIDTH-1:0];

      accsum_c    = pe_calc_t'(acc) + prod_c;
      acc_c       = sat_signed(accsum_c, ACC_WIDTH, SAT_EN);
      acc_ovf     = ~fits_signed(accsum_c, ACC_WIDTH);
      acc_sum     = acc_c[ACC_WIDTH-1:0];

      // Accumulator carries 2*FRAC_BITS fraction; bring it back to Q format.
      drain_raw_c = fxp_round_shift(pe_calc_t'(acc), FRAC_BITS);
      drain_c     = sat_signed(drain_raw_c, DATA_WIDTH, SAT_EN);
      drain_ovf   = ~fits_signed(drain_raw_c, DATA_WIDTH);
      drain_psum  = drain_c[DATA_WIDTH-1:0];
   end

endmodule

// File: rtl/pe_fxp_wsos.sv
// Systolic processing element with run-time WS/OS dataflow, double-buffered
// weights, registered east/south forwarding and sticky status flags.
module pe_fxp_wsos
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = PE_DATA_WIDTH_DEF,
   parameter int FRAC_BITS  = PE_FRAC_BITS_DEF,
   parameter int ACC_WIDTH  = PE_ACC_WIDTH_DEF,
   parameter int SATURATE   = PE_SATURATE_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         pe_enabled,
   input  logic                         pe_mode_os,
   input  logic signed [DATA_WIDTH-1:0] pe_psum_in,
   input  logic                         pe_psum_valid_in,
   input  logic signed [DATA_WIDTH-1:0] pe_weight_in,
   input  logic                         pe_accept_w_in,
   input  logic signed [DATA_WIDTH-1:0] pe_input_in,
   input  logic                         pe_valid_in,
   input  logic                         pe_switch_in,
   input  logic                         pe_drain_in,
   input  logic                         pe_ovf_clr,
   output logic signed [DATA_WIDTH-1:0] pe_psum_out,
   output logic                         pe_psum_valid_out,
   output logic signed [DATA_WIDTH-1:0] pe_weight_out,
   output logic                         pe_accept_w_out,
   output logic signed [DATA_WIDTH-1:0] pe_input_out,
   output logic                         pe_valid_out,
   output logic                         pe_switch_out,
   output logic                         pe_drain_out,
   output logic                         pe_ovf_sticky,
   output logic                         pe_err_sticky
);

   logic signed [DATA_WIDTH-1:0] active_w;
   logic signed [DATA_WIDTH-1:0] inactive_w;
   logic signed [ACC_WIDTH-1:0]  acc;
   pe_mode_e                     mode;
   pe_mode_e                     mode_prev;
   logic                         mode_seen;
   logic                         mode_change;
   logic                         ovf_event;
   logic                         err_event;

   logic signed [DATA_WIDTH-1:0] ws_psum;
   logic                         ws_ovf;
   logic signed [ACC_WIDTH-1:0]  acc_sum;
   logic                         acc_ovf;
   logic signed [ACC_WIDTH-1:0]  prod_ext;
   logic signed [DATA_WIDTH-1:0] drain_psum;
   logic                         drain_ovf;

   pe_fxp_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .ACC_WIDTH  (ACC_WIDTH),
      .SATURATE   (SATURATE)
   ) u_mac (
      .act_in     (pe_input_in),
      .weight     (active_w),
      .psum_in    (pe_psum_in),
      .acc        (acc),
      .ws_psum    (ws_psum),
      .ws_ovf     (ws_ovf),
      .acc_sum    (acc_sum),
      .acc_ovf    (acc_ovf),
      .prod_ext   (prod_ext),
      .drain_psum (drain_psum),
      .drain_ovf  (drain_ovf)
   );

   // Decode mode, detect a mode change and collect this cycle's flag events.
   always_comb begin
      mode        = pe_mode_e'(pe_mode_os);
      mode_change = mode_seen & (mode != mode_prev);
      ovf_event   = 1'b0;
      err_event   = 1'b0;
      if (mode == PE_MODE_WS) begin
         if (pe_valid_in) begin
            ovf_event = ws_ovf;
         end else begin
            ovf_event = 1'b0;
         end
      end else begin
         if (pe_drain_in) begin
            ovf_event = drain_ovf;
            err_event = pe_psum_valid_in;
         end else if (pe_valid_in) begin
            ovf_event = acc_ovf;
         end else begin
            ovf_event = 1'b0;
         end
      end
   end

   // Forward control strobes and activation/weight data east/south.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_valid_out    <= 1'b0;
         pe_switch_out   <= 1'b0;
         pe_drain_out    <= 1'b0;
         pe_accept_w_out <= 1'b0;
         pe_input_out    <= {DATA_WIDTH{1'b0}};
         pe_weight_out   <= {DATA_WIDTH{1'b0}};
      end else if (pe_enabled) begin
         pe_valid_out    <= pe_valid_in;
         pe_switch_out   <= pe_switch_in;
         pe_drain_out    <= pe_drain_in;
         pe_accept_w_out <= pe_accept_w_in;
         if (pe_valid_in) begin
            pe_input_out <= pe_input_in;
         end
         pe_weight_out   <= pe_accept_w_in ? pe_weight_in : {DATA_WIDTH{1'b0}};
      end else begin
         // Strobes drop while stalled so downstream never sees an event twice.
         pe_valid_out    <= 1'b0;
         pe_switch_out   <= 1'b0;
         pe_drain_out    <= 1'b0;
         pe_accept_w_out <= 1'b0;
      end
   end

   // Weight double buffer; a same-cycle switch picks up the old inactive value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_w   <= {DATA_WIDTH{1'b0}};
         inactive_w <= {DATA_WIDTH{1'b0}};
      end else if (pe_enabled) begin
         if (pe_accept_w_in) begin
            inactive_w <= pe_weight_in;
         end
         if (pe_switch_in) begin
            active_w <= inactive_w;
         end
      end
   end

   // Psum output path for both dataflows plus the OS accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_psum_out       <= {DATA_WIDTH{1'b0}};
         pe_psum_valid_out <= 1'b0;
         acc               <= {ACC_WIDTH{1'b0}};
         mode_prev         <= PE_MODE_WS;
         mode_seen         <= 1'b0;
      end else if (pe_enabled) begin
         mode_prev <= mode;
         mode_seen <= 1'b1;

         if (mode == PE_MODE_WS) begin
            pe_psum_valid_out <= pe_valid_in;
            pe_psum_out       <= pe_valid_in ? ws_psum : {DATA_WIDTH{1'b0}};
         end else if (pe_drain_in) begin
            // Own result wins over any pass-through arriving this cycle.
            pe_psum_valid_out <= 1'b1;
            pe_psum_out       <= drain_psum;
         end else if (pe_psum_valid_in) begin
            pe_psum_valid_out <= 1'b1;
            pe_psum_out       <= pe_psum_in;
         end else begin
            pe_psum_valid_out <= 1'b0;
         end

         if (mode_change) begin
            acc <= {ACC_WIDTH{1'b0}};
         end else if (mode == PE_MODE_OS) begin
            if (pe_drain_in) begin
               acc <= pe_valid_in ? prod_ext : {ACC_WIDTH{1'b0}};
            end else if (pe_valid_in) begin
               acc <= acc_sum;
            end
         end
      end else begin
         pe_psum_valid_out <= 1'b0;
      end
   end

   // Sticky overflow/collision flags; clear beats a same-cycle set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe_ovf_sticky <= 1'b0;
         pe_err_sticky <= 1'b0;
      end else if (pe_enabled) begin
         if (pe_ovf_clr) begin
            pe_ovf_sticky <= 1'b0;
            pe_err_sticky <= 1'b0;
         end else begin
            pe_ovf_sticky <= pe_ovf_sticky | ovf_event;
            pe_err_sticky <= pe_err_sticky | err_event;
         end
      end
   end

endmodule

// File: tb/tb_pe_fxp_wsos.sv
// Self-checking bench for pe_fxp_wsos (Q8.8 defaults): directed cases with
// literal expectations, then randomized traffic against a behavioural model.
module tb_pe_fxp_wsos;

   localparam int DW = 16;
   localparam int F  = 8;
   localparam int AW = 40;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          en = 1'b1;
   logic          mode = 1'b0;
   logic [DW-1:0] psum_in = '0;
   logic          pvin = 1'b0;
   logic [DW-1:0] w_in = '0;
   logic          acc_w = 1'b0;
   logic [DW-1:0] in_v = '0;
   logic          vin = 1'b0;
   logic          sw = 1'b0;
   logic          dr = 1'b0;
   logic          clr = 1'b0;

   logic [DW-1:0] psum_out, weight_out, input_out;
   logic          psum_vout, accept_w_out, valid_out, switch_out, drain_out, ovf_st, err_st;
   logic [DW-1:0] psum_out2, weight_out2, input_out2;
   logic          psum_vout2, accept_w_out2, valid_out2, switch_out2, drain_out2, ovf_st2, err_st2;

   pe_fxp_wsos #(.DATA_WIDTH(DW), .FRAC_BITS(F), .ACC_WIDTH(AW), .SATURATE(1)) dut (
      .clk(clk), .rst_n(rst_n), .pe_enabled(en), .pe_mode_os(mode),
      .pe_psum_in(psum_in), .pe_psum_valid_in(pvin), .pe_weight_in(w_in),
      .pe_accept_w_in(acc_w), .pe_input_in(in_v), .pe_valid_in(vin),
      .pe_switch_in(sw), .pe_drain_in(dr), .pe_ovf_clr(clr),
      .pe_psum_out(psum_out), .pe_psum_valid_out(psum_vout), .pe_weight_out(weight_out),
      .pe_accept_w_out(accept_w_out), .pe_input_out(input_out), .pe_valid_out(valid_out),
      .pe_switch_out(switch_out), .pe_drain_out(drain_out),
      .pe_ovf_sticky(ovf_st), .pe_err_sticky(err_st));

   // Wrapping variant, checked only at the saturation case.
   pe_fxp_wsos #(.DATA_WIDTH(DW), .FRAC_BITS(F), .ACC_WIDTH(AW), .SATURATE(0)) dut_wrap (
      .clk(clk), .rst_n(rst_n), .pe_enabled(en), .pe_mode_os(mode),
      .pe_psum_in(psum_in), .pe_psum_valid_in(pvin), .pe_weight_in(w_in),
      .pe_accept_w_in(acc_w), .pe_input_in(in_v), .pe_valid_in(vin),
      .pe_switch_in(sw), .pe_drain_in(dr), .pe_ovf_clr(clr),
      .pe_psum_out(psum_out2), .pe_psum_valid_out(psum_vout2), .pe_weight_out(weight_out2),
      .pe_accept_w_out(accept_w_out2), .pe_input_out(input_out2), .pe_valid_out(valid_out2),
      .pe_switch_out(switch_out2), .pe_drain_out(drain_out2),
      .pe_ovf_sticky(ovf_st2), .pe_err_sticky(err_st2));

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   bit chk_on  = 1'b0;

   // Behavioural model state: numeric weights/accumulator and expected outputs.
   longint        m_act, m_inact, m_acc;
   bit            m_mode, m_seen;
   logic [DW-1:0] e_psum, e_wout, e_in;
   bit            e_pv, e_aw, e_v, e_sw, e_dr, e_ovf, e_err;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Signed range limit, clamped or wrapped, reporting whether it was out of range.
   function automatic longint clampv(input longint v, input int w, input bit sat, output bit o);
      longint lim, m;
      lim = longint'(1) << (w - 1);
      o = (v > lim - 1) || (v < -lim);
      if (!o) return v;
      if (sat) return (v < 0) ? -lim : lim - 1;
      m = v & ((lim << 1) - 1);
      if (m >= lim) m = m - (lim << 1);
      return m;
   endfunction

   task automatic model_reset();
      m_act = 0; m_inact = 0; m_acc = 0; m_mode = 0; m_seen = 0;
      e_psum = '0; e_wout = '0; e_in = '0;
      e_pv = 0; e_aw = 0; e_v = 0; e_sw = 0; e_dr = 0; e_ovf = 0; e_err = 0;
   endtask

   task automatic model_step();
      longint p, v;
      bit o, ovf_ev, err_ev;
      ovf_ev = 0; err_ev = 0;
      if (!en) begin
         e_v = 0; e_sw = 0; e_dr = 0; e_aw = 0; e_pv = 0;
         return;
      end
      p = longint'($signed(in_v)) * m_act;
      e_v = vin; e_sw = sw; e_dr = dr; e_aw = acc_w;
      e_wout = acc_w ? w_in : 16'h0000;
      if (vin) e_in = in_v;
      if (!mode) begin
         if (vin) begin
            v = clampv(((p + 128) >>> F) + longint'($signed(psum_in)), DW, 1, o);
            e_psum = DW'(v); e_pv = 1; ovf_ev = o;
         end else begin
            e_psum = '0; e_pv = 0;
         end
      end else if (dr) begin
         v = clampv((m_acc + 128) >>> F, DW, 1, o);
         e_psum = DW'(v); e_pv = 1; ovf_ev = o; err_ev = pvin;
      end else if (pvin) begin
         e_psum = psum_in; e_pv = 1;
      end else begin
         e_pv = 0;
      end
      if (m_seen && (mode != m_mode)) m_acc = 0;
      else if (mode) begin
         if (dr) m_acc = vin ? p : 0;
         else if (vin) begin
            m_acc = clampv(m_acc + p, AW, 1, o);
            ovf_ev = ovf_ev | o;
         end
      end
      m_seen = 1; m_mode = mode;
      if (sw) m_act = m_inact;
      if (acc_w) m_inact = longint'($signed(w_in));
      if (clr) begin
         e_ovf = 0; e_err = 0;
      end else begin
         e_ovf = e_ovf | ovf_ev; e_err = e_err | err_ev;
      end
   endtask

   // Compare every DUT output against the model once per cycle, away from the edge.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("psum_out", psum_out, e_psum);
         chk("psum_valid_out", psum_vout, e_pv);
         chk("weight_out", weight_out, e_wout);
         chk("accept_w_out", accept_w_out, e_aw);
         chk("input_out", input_out, e_in);
         chk("valid_out", valid_out, e_v);
         chk("switch_out", switch_out, e_sw);
         chk("drain_out", drain_out, e_dr);
         chk("ovf_sticky", ovf_st, e_ovf);
         chk("err_sticky", err_st, e_err);
      end
   end

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle();
      acc_w = 0; sw = 0; vin = 0; dr = 0; pvin = 0; clr = 0; en = 1;
   endtask

   function automatic logic [DW-1:0] rnd_val();
      if ($urandom_range(0, 1) == 0) return DW'($urandom);
      return DW'($urandom_range(0, 2047)) - 16'd1024;
   endfunction

   initial begin
      model_reset();
      #1 rst_n = 1'b0;
      #12;
      chk("reset_psum", psum_out, 16'h0000);
      chk("reset_pvalid", psum_vout, 1'b0);
      chk("reset_ovf", ovf_st, 1'b0);
      chk("reset_err", err_st, 1'b0);
      chk("reset_wout", weight_out, 16'h0000);
      chk("reset_input", input_out, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      chk_on = 1'b1;

      // WS MAC: 2.0 * 1.5 + 1.0 = 4.0
      acc_w = 1; w_in = 16'h0200; step();
      acc_w = 0; sw = 1; step();
      sw = 0; vin = 1; in_v = 16'h0180; psum_in = 16'h0100; step();
      chk("ws_mac", psum_out, 16'h0400);
      chk("ws_mac_valid", psum_vout, 1'b1);
      chk("model_ws_mac", e_psum, 16'h0400);
      vin = 0;

      // Rounding half up at 0.5 weight
      acc_w = 1; w_in = 16'h0080; step();
      acc_w = 0; sw = 1; step();
      sw = 0; vin = 1; in_v = 16'h0001; psum_in = 16'h0000; step();
      chk("round_pos", psum_out, 16'h0001);
      in_v = 16'hFFFF; step();
      chk("round_neg", psum_out, 16'h0000);
      chk("model_round_neg", e_psum, 16'h0000);
      vin = 0;

      // Saturation vs wrap
      acc_w = 1; w_in = 16'h7F00; step();
      acc_w = 0; sw = 1; step();
      sw = 0; vin = 1; in_v = 16'h7F00; step();
      chk("sat_value", psum_out, 16'h7FFF);
      chk("sat_flag", ovf_st, 1'b1);
      chk("model_sat", e_psum, 16'h7FFF);
      chk("wrap_value", psum_out2, 16'h0100);
      chk("wrap_flag", ovf_st2, 1'b1);
      vin = 0; clr = 1; step();
      chk("ovf_clr", ovf_st, 1'b0);
      chk("ovf_clr_wrap", ovf_st2, 1'b0);
      clr = 0;

      // Weight race: switch takes old inactive, accept loads new
      acc_w = 1; w_in = 16'h0300; step();
      w_in = 16'h0500; sw = 1; step();
      chk("race_wout", weight_out, 16'h0500);
      chk("race_accept", accept_w_out, 1'b1);
      acc_w = 0; sw = 0; vin = 1; in_v = 16'h0100; psum_in = 16'h0000; step();
      chk("race_active_old", psum_out, 16'h0300);
      vin = 0; sw = 1; step();
      sw = 0; vin = 1; step();
      chk("race_inactive_new", psum_out, 16'h0500);
      vin = 0;

      // OS accumulate and drain
      mode = 1; step();
      acc_w = 1; w_in = 16'h0100; step();
      acc_w = 0; sw = 1; step();
      sw = 0; vin = 1; in_v = 16'h0100;
      for (int i = 0; i < 4; i++) step();
      vin = 0; dr = 1; step();
      chk("os_drain", psum_out, 16'h0400);
      chk("os_drain_valid", psum_vout, 1'b1);
      chk("model_os_drain", e_psum, 16'h0400);
      vin = 1; in_v = 16'h0200; step();
      vin = 0; dr = 0; step();
      dr = 1; step();
      chk("os_restart", psum_out, 16'h0200);
      dr = 0;

      // Collision and pass-through
      vin = 1; in_v = 16'h0300; step();
      vin = 0; dr = 1; pvin = 1; psum_in = 16'h1234; step();
      chk("collision_own", psum_out, 16'h0300);
      chk("collision_err", err_st, 1'b1);
      dr = 0; step();
      chk("passthrough", psum_out, 16'h1234);
      pvin = 0;

      // Stall: everything held, strobes zero
      en = 0; vin = 1; dr = 1; sw = 1; acc_w = 1; pvin = 1; clr = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_hold", psum_out, 16'h1234);
         chk("stall_pvalid", psum_vout, 1'b0);
         chk("stall_err_hold", err_st, 1'b1);
      end
      idle();

      // Reset while the accumulator holds a nonzero value
      vin = 1; in_v = 16'h0100; step(); step();
      @(posedge clk);
      model_step();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_psum", psum_out, 16'h0000);
      chk("midrst_err", err_st, 1'b0);
      chk("midrst_input", input_out, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      vin = 0; dr = 1; step();
      chk("post_rst_drain", psum_out, 16'h0000);
      chk("post_rst_valid", psum_vout, 1'b1);
      idle();

      // Randomized traffic
      for (int i = 0; i < 1500; i++) begin
         en    = ($urandom_range(0, 7) != 0);
         vin   = $urandom_range(0, 1);
         acc_w = ($urandom_range(0, 3) == 0);
         sw    = ($urandom_range(0, 6) == 0);
         dr    = ($urandom_range(0, 9) == 0);
         pvin  = ($urandom_range(0, 3) == 0);
         clr   = ($urandom_range(0, 19) == 0);
         in_v  = rnd_val();
         w_in  = rnd_val();
         psum_in = rnd_val();
         if ($urandom_range(0, 49) == 0) begin
            mode = ~mode; en = 1; vin = 0; dr = 0; pvin = 0;
         end
         step();
      end
      idle();
      step();

      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pe_fxp_wsos.md
Name: pe_fxp_wsos

Overview:
- Parametrised successor to the systolic processing element; a drop-in replacement for the array tile.
- Generic data width and Q-format with round-half-up and optional saturation.
- Two dataflows selectable at run time:
  - weight-stationary (WS): psum flows south;
  - output-stationary (OS): local wide accumulator, drained south on command.
- Double-buffered weights with registered forwarding of data, control and weight-load strobes east/south, plus sticky overflow/collision status.

Parameters:
DATA_WIDTH, 16, width of inputs, weights, psums.
FRAC_BITS, 8, fractional bits of Q format (1 <= FRAC_BITS < DATA_WIDTH).
ACC_WIDTH, 40, OS accumulator width at 2*FRAC_BITS fraction (>= 2*DATA_WIDTH).
SATURATE, 1, 1 = clamp on overflow, 0 = two's-complement wrap (overflow still flagged).

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
pe_enabled  in  1  clock-enable; low = data/state registers hold.
pe_mode_os  in  1  0 = WS, 1 = OS; quasi-static.
pe_psum_in  in  DATA_WIDTH  signed psum from north.
pe_psum_valid_in  in  1  qualifies pe_psum_in (OS pass-through).
pe_weight_in  in  DATA_WIDTH  signed weight from north.
pe_accept_w_in  in  1  load weight into inactive buffer.
pe_input_in  in  DATA_WIDTH  signed activation from west.
pe_valid_in  in  1  qualifies pe_input_in.
pe_switch_in  in  1  swap inactive buffer into active.
pe_drain_in  in  1  OS: emit accumulator south.
pe_ovf_clr  in  1  clears sticky flags.
pe_psum_out  out  DATA_WIDTH  psum south.
pe_psum_valid_out  out  1  qualifies pe_psum_out.
pe_weight_out  out  DATA_WIDTH  forwarded weight.
pe_accept_w_out  out  1  forwarded accept strobe.
pe_input_out  out  DATA_WIDTH  forwarded activation.
pe_valid_out, pe_switch_out, pe_drain_out  out  1 each  forwarded west controls.
pe_ovf_sticky  out  1  any saturation/wrap event since clear.
pe_err_sticky  out  1  OS drain/pass-through collision since clear.

Behaviour:
- Reset: asynchronous, on rst_n low. All outputs, both weight buffers, the accumulator and the sticky flags go to 0.
- Latency: every output is registered, one cycle after its input.
- Control forwarding: when enabled, each control output is registered from its input (valid, switch, drain, accept_w).
- Data forwarding:
  - pe_input_out updates only when pe_valid_in = 1, else holds.
  - pe_weight_out = pe_weight_in when pe_accept_w_in = 1, else 0.
- Weights:
  - accept: inactive <= pe_weight_in.
  - switch: active <= inactive.
  - Both in the same cycle: active takes the OLD inactive value and inactive takes the new weight.
- Product: p = pe_input_in * active, full 2*DATA_WIDTH signed. Rounded value r = (p + 2^(FRAC_BITS-1)) >>> FRAC_BITS.
- WS mode, when pe_valid_in = 1:
  - psum_out <= clampDW(r + pe_psum_in);
  - psum_valid_out <= 1.
- WS mode, when pe_valid_in = 0: psum_out <= 0 and psum_valid_out <= 0.
- OS mode accumulation: when pe_valid_in = 1, acc <= clampACC(acc + p).
- OS mode drain (pe_drain_in = 1):
  - psum_out <= clampDW(round(acc) >>> FRAC_BITS), psum_valid_out <= 1.
  - The accumulator restarts: acc <= (pe_valid_in ? p : 0).
- OS pass-through: when pe_psum_valid_in = 1 and there is no drain, psum_out <= pe_psum_in and psum_valid_out <= 1.
- OS collision: drain and pe_psum_valid_in in the same cycle. The own value wins, the pass-through value is dropped, and pe_err_sticky sets.
- Overflow/clamp rules:
  - clampX is saturation to the signed X-bit range when SATURATE = 1, otherwise truncation.
  - Any out-of-range result sets pe_ovf_sticky in both cases.
  - The intermediate sum r + pe_psum_in is computed at DATA_WIDTH+FRAC_BITS+2 bits before clamping.
- Mode change: any change of pe_mode_os clears acc in the following cycle. Data in flight during the change is undefined; the controller changes mode only with valid, drain and psum_valid all low.
- pe_enabled = 0:
  - weights, acc, data outputs and sticky flags hold;
  - all 1-bit strobe outputs (valid, psum_valid, switch, drain, accept_w) register 0, so no duplicate events;
  - inputs that cycle are ignored.
- pe_ovf_clr: clears both sticky flags. It takes priority over a set event in the same cycle.
- Reset mid-operation: immediate clear. Accumulate and drain resume cleanly after rst_n deasserts.

Decomposition:
- pe_pkg holds:
  - typedef enum logic {PE_MODE_WS, PE_MODE_OS} pe_mode_e;
  - localparam defaults;
  - functions fxp_round_shift and sat_signed, parameterised via width arguments.
- One combinational sub-module, pe_fxp_mac. It covers multiply, round, add, clamp and overflow detection for both the WS psum path and the OS drain path. It replaces fxp_mul/fxp_add inside this PE.
- The top level holds only registers, mode and collision logic.

Test Plan (defaults, Q8.8):
- WS MAC: accept 0x0200, switch, then input 0x0180 with psum_in 0x0100 -> psum_out 0x0400, psum_valid_out 1 one cycle later.
- Round/saturate:
  - active 0x0080, input 0x0001 -> 0x0001; input 0xFFFF -> 0x0000.
  - active 0x7F00, input 0x7F00 -> 0x7FFF with pe_ovf_sticky = 1; with SATURATE = 0, the wrapped value and the flag still set.
  - pe_ovf_clr -> flag 0.
- OS: active 0x0100, four valid inputs of 0x0100, then drain -> psum_out 0x0400. Drain with a simultaneous valid input 0x0200 -> next drain gives 0x0200.
- Weight race: inactive 0x0300, accept 0x0500 and switch in the same cycle -> active 0x0300, inactive 0x0500. pe_weight_out 0x0500 and pe_accept_w_out 1 the next cycle.
- Collision/enable: OS drain with pe_psum_valid_in 1 (psum_in 0x1234) -> own result out, pe_err_sticky 1. pe_enabled low for 3 cycles -> outputs hold, strobes 0.
- Reset: assert rst_n low mid-accumulate (acc nonzero) -> all outputs and flags 0 immediately. After release, drain -> 0x0000.
